// File: rtl/aim_vector_gen.sv
// aim_vector_gen: turns a click position into a signed Q1.8 unit aim vector
// using one shared iterative datapath (square, sqrt, two divides).
module aim_vector_gen #(
  parameter int CENTER_X    = 320,
  parameter int CENTER_Y    = 240,
  parameter int SCALE_SHIFT = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [9:0]        ClickX,
  input  logic [9:0]        ClickY,
  input  logic              leftButton,
  output logic signed [8:0] x_vector,
  output logic signed [8:0] y_vector,
  output logic              vec_valid,
  output logic              busy
);
  typedef enum logic [2:0] {IDLE, SQ, SQRT, DIVX, DIVY, DONE} state_t;
  state_t state, state_n;
  logic        btn_prev, accept;
  logic [4:0]  cnt;
  logic [9:0]  cx, cy, adx, ady;
  logic [8:0]  ax, ay, root, root_n;
  logic        sx, sy;
  logic [17:0] rad;
  logic [11:0] rem, rem_sh, trial, rem_n;
  logic        sq_ge, dv_ge;
  logic [16:0] dvd, q, q_n;
  logic [9:0]  r, t, r_n;
  logic [7:0]  qx, mag_n;
  assign accept = state == IDLE && leftButton && !btn_prev;
  always_comb begin
    cx  = ClickX > 10'd639 ? 10'd639 : ClickX;
    cy  = ClickY > 10'd479 ? 10'd479 : ClickY;
    adx = cx < 10'(CENTER_X) ? 10'(CENTER_X) - cx : cx - 10'(CENTER_X);
    ady = cy > 10'(CENTER_Y) ? cy - 10'(CENTER_Y) : 10'(CENTER_Y) - cy;
  end
  // One restoring-sqrt step consumes the top two radicand bits per cycle.
  always_comb begin
    rem_sh = {rem[9:0], rad[17:16]};
    trial  = {1'b0, root, 2'b01};
    sq_ge  = rem_sh >= trial;
    rem_n  = sq_ge ? rem_sh - trial : rem_sh;
    root_n = {root[7:0], sq_ge};
  end
  // One restoring-division step; the remainder always stays below len.
  always_comb begin
    t     = {r[8:0], dvd[16]};
    dv_ge = t >= {1'b0, root};
    r_n   = dv_ge ? t - {1'b0, root} : t;
    q_n   = {q[15:0], dv_ge};
    mag_n = |q_n[16:8] ? 8'd255 : q_n[7:0];
  end
  always_ff @(posedge Clk)
    if (Reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = accept ? SQ : IDLE;
      SQ:      state_n = SQRT;
      SQRT:    state_n = cnt == 5'd8 ? DIVX : SQRT;
      DIVX:    state_n = cnt == 5'd16 ? DIVY : DIVX;
      DIVY:    state_n = cnt == 5'd16 ? DONE : DIVY;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    busy      = state != IDLE;
    vec_valid = state == DONE;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      btn_prev <= 1'b1;
      cnt      <= '0;
      ax <= '0; ay <= '0; sx <= 1'b0; sy <= 1'b0;
      rad <= '0; rem <= '0; root <= '0;
      dvd <= '0; r <= '0; q <= '0; qx <= '0;
      x_vector <= '0;
      y_vector <= '0;
    end else begin
      btn_prev <= leftButton;
      cnt      <= state_n != state ? 5'd0 : cnt + 5'd1;
      if (accept) begin
        ax <= adx[8:0];
        ay <= ady[8:0];
        sx <= cx < 10'(CENTER_X);
        sy <= cy > 10'(CENTER_Y);
      end
      if (state == SQ) begin
        rad  <= 18'(ax) * 18'(ax) + 18'(ay) * 18'(ay);
        rem  <= '0;
        root <= '0;
      end
      if (state == SQRT) begin
        rad  <= rad << 2;
        rem  <= rem_n;
        root <= root_n;
      end
      if (state == DIVX || state == DIVY) begin
        dvd <= dvd << 1;
        r   <= r_n;
        q   <= q_n;
      end
      if (state == SQRT && cnt == 5'd8) begin
        dvd <= 17'(ax) << SCALE_SHIFT;
        r   <= '0;
        q   <= '0;
      end
      if (state == DIVX && cnt == 5'd16) begin
        qx  <= mag_n;
        dvd <= 17'(ay) << SCALE_SHIFT;
        r   <= '0;
        q   <= '0;
      end
      if (state == DIVY && cnt == 5'd16) begin
        x_vector <= root == '0 ? 9'sd0 : sx ? -$signed({1'b0, qx}) : $signed({1'b0, qx});
        y_vector <= root == '0 ? 9'sd255 : sy ? -$signed({1'b0, mag_n}) : $signed({1'b0, mag_n});
      end
    end
  end
endmodule

// File: tb/tb_aim_vector_gen.sv
// tb_aim_vector_gen: directed click vectors with hand-computed aim vectors.
module tb_aim_vector_gen;
  logic              Clk = 1'b0;
  logic              Reset = 1'b1;
  logic [9:0]        ClickX = '0, ClickY = '0;
  logic              leftButton = 1'b1;
  logic signed [8:0] x_vector, y_vector;
  logic              vec_valid, busy;
  int checks = 0, failures = 0;

  aim_vector_gen dut (
    .Clk(Clk), .Reset(Reset), .ClickX(ClickX), .ClickY(ClickY),
    .leftButton(leftButton), .x_vector(x_vector), .y_vector(y_vector),
    .vec_valid(vec_valid), .busy(busy)
  );

  always #10 Clk = ~Clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // mode 0: plain click, 1: extra edge at N+10, 2: edge in DONE, 3: edge in first IDLE
  task automatic click(input [9:0] x, input [9:0] y, input int ex, input int ey, input int mode);
    int pulses = 0;
    @(negedge Clk);
    ClickX = x; ClickY = y; leftButton = 1'b1;
    for (int k = 1; k <= 46; k++) begin
      @(negedge Clk);
      if (vec_valid) pulses++;
      if (k == 1) chk("busy_start", busy, 1);
      if (k == 44) chk("vv_early", vec_valid, 0);
      if (k == 45) begin
        chk("vv_done", vec_valid, 1);
        chk("busy_done", busy, 1);
        chk("x_vec", x_vector, ex);
        chk("y_vec", y_vector, ey);
      end
      if (k == 46) begin
        chk("busy_end", busy, 0);
        chk("vv_end", vec_valid, 0);
        chk("pulses", pulses, 1);
        chk("x_hold", x_vector, ex);
        chk("y_hold", y_vector, ey);
      end
      leftButton = (mode == 1 && k >= 10 && k <= 12) || (mode == 2 && k >= 45) ||
                   (mode == 3 && k == 46);
    end
  endtask

  initial begin
    repeat (3) @(negedge Clk);
    chk("rst_x", x_vector, 0);
    chk("rst_y", y_vector, 0);
    chk("rst_vv", vec_valid, 0);
    chk("rst_busy", busy, 0);
    Reset = 1'b0;
    repeat (4) @(negedge Clk);
    chk("held_btn_busy", busy, 0);
    leftButton = 1'b0;
    repeat (2) @(negedge Clk);

    click(10'd420, 10'd240, 255, 0, 0);
    click(10'd240, 10'd300, -204, -153, 1);
    click(10'd320, 10'd240, 0, 255, 0);
    click(10'd1000, 10'd600, 205, -153, 2);
    repeat (3) @(negedge Clk);
    chk("done_edge_dropped", busy, 0);
    leftButton = 1'b0;
    @(negedge Clk);
    click(10'd240, 10'd300, -204, -153, 3);
    @(negedge Clk);
    chk("idle_edge_accepted", busy, 1);
    leftButton = 1'b0;
    repeat (50) @(negedge Clk);
    chk("idle_edge_x", x_vector, -204);

    begin
      int pulses = 0;
      int busy_cycles = 0;
      ClickX = 10'd200; ClickY = 10'd100; leftButton = 1'b1;
      for (int k = 1; k <= 20; k++) begin
        @(negedge Clk);
        leftButton = k == 20;
        if (k == 20) Reset = 1'b1;
      end
      @(negedge Clk);
      chk("mid_rst_x", x_vector, 0);
      chk("mid_rst_y", y_vector, 0);
      chk("mid_rst_vv", vec_valid, 0);
      chk("mid_rst_busy", busy, 0);
      Reset = 1'b0;
      for (int k = 0; k < 60; k++) begin
        @(negedge Clk);
        if (vec_valid) pulses++;
        if (busy) busy_cycles++;
      end
      chk("post_rst_pulses", pulses, 0);
      chk("post_rst_busy", busy_cycles, 0);
      leftButton = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
